// File: rtl/twos_comp_pkg.sv
// Shared definitions for the bit-serial two's complement sequencer.
package twos_comp_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reference negation (~x)+1, truncated to w bits.
  function automatic logic [MAX_WIDTH-1:0] neg_ref(input logic [MAX_WIDTH-1:0] x,
                                                   input int unsigned w);
    logic [MAX_WIDTH-1:0] mask;
    mask = (w >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << w) - MAX_WIDTH'(1));
    return ((~x) + MAX_WIDTH'(1)) & mask;
  endfunction

endpackage

// File: rtl/twos_comp_bit_cell.sv
// One-bit negation cell: copies bits up to the first 1, inverts after it.
module twos_comp_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic b,
  input  logic neg,
  output logic obit,
  output logic seen_one
);

  // Invert only once a 1 has already passed through, and only when negating.
  assign obit = (neg && seen_one) ? ~b : b;

  // Remember whether any 1 has been consumed in the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one <= 1'b0;
    end else if (clear) begin
      seen_one <= 1'b0;
    end else if (enable) begin
      seen_one <= seen_one | b;
    end
  end

endmodule

// File: rtl/twos_comp_serial_ctrl.sv
// Bit-serial two's complement sequencer with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an input word, in_ready high
// SHIFT | consuming one bit per clock, LSB first
// DONE  | result held on out_data until out_ready
module twos_comp_serial_ctrl
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("twos_comp_serial_ctrl: WIDTH out of range");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             neg_q;
  logic             b;
  logic             obit;
  logic             seen_one;
  logic             cell_clear;
  logic             cell_en;
  logic             last_bit;

  assign b          = shreg[0];
  assign cell_clear = (state == IDLE);
  assign cell_en    = (state == SHIFT);
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign result_nxt = {obit, result[WIDTH-1:1]};

  twos_comp_bit_cell u_cell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cell_clear),
    .enable   (cell_en),
    .b        (b),
    .neg      (neg_q),
    .obit     (obit),
    .seen_one (seen_one)
  );

  // Sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      result    <= '0;
      bit_cnt   <= '0;
      neg_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            neg_q    <= in_neg;
            bit_cnt  <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          result <= result_nxt;
          shreg  <= shreg >> 1;
          if (last_bit) begin
            // Overflow: the only 1 in the word sits in the MSB.
            out_data  <= result_nxt;
            out_ovf   <= neg_q & ~seen_one & b;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/twos_comp_serial_ctrl.md
Name: twos_comp_serial_ctrl

Overview:
Sequencer for a bit-serial two's complement (negation) engine. It accepts a WIDTH-bit word on a valid/ready input handshake and processes it LSB-first, one bit per clock. The rule is: copy bits up to and including the first 1, then invert every later bit. The result is presented on a valid/ready output handshake. It replaces the parallel subtract-and-add negator wherever area matters more than throughput.

Parameters:
WIDTH, 4, data word width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word available.
in_ready  output  1  controller can accept a word this cycle.
in_data  input  WIDTH  word to convert; unsigned bit pattern.
in_neg  input  1  sampled with in_data; 1 = output the two's complement, 0 = pass the word through unchanged.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
out_data  output  WIDTH  converted word, equal to (2^WIDTH - in_data) mod 2^WIDTH when in_neg=1.
out_ovf  output  1  in_neg=1 and in_data = 1 followed by zeros (most negative value); out_data then equals in_data.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_data=0; out_ovf=0; busy=0; all internal registers cleared.
- FSM states: IDLE, SHIFT, DONE. Encoding comes from the shared package.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the shift register and in_neg into neg_q. Clear seen_one, bit_cnt=0, result=0. Go to SHIFT.
- SHIFT:
  - in_ready=0. One bit per cycle: b = shift register LSB.
  - If neg_q=1: obit = seen_one ? ~b : b. If neg_q=0: obit = b.
  - seen_one <= seen_one | b.
  - result shifts right with obit entering at the MSB. The input shift register shifts right.
  - bit_cnt increments.
  - When bit_cnt==WIDTH-1: go to DONE on the same edge as the last bit.
- DONE:
  - out_valid=1. out_data and out_ovf are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE and deassert out_valid.
  - out_data keeps its last value after the handshake and is don't-care.
- Latency: if the input is accepted on edge T, out_valid rises after edge T+WIDTH. Minimum spacing between accepted words is WIDTH+2 cycles. in_ready is low in SHIFT and DONE; there is no overlap.
- out_ovf: registered into DONE. Set if neg_q=1, the only 1 seen was at bit WIDTH-1, and every lower bit was 0. Zero input gives out_data=0 and out_ovf=0.
- Pass-through (in_neg=0) takes the same WIDTH-cycle latency so that timing is uniform.
- in_valid asserted while busy is ignored. Upstream must hold its word until in_ready.
- out_ready low in DONE holds indefinitely. No data loss.
- rst_n asserted in any state discards the in-flight word immediately and restores the reset values. The first acceptance is possible on the first rising edge after rst_n deasserts.
- bit_cnt width is $clog2(WIDTH). It never wraps within a word.

Decomposition:
- Shared package twos_comp_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the WIDTH legality bounds (MIN_WIDTH=2, MAX_WIDTH=32);
  - a function for the reference model, (~x)+1 truncated to WIDTH, for bench use.
- One sub-module: twos_comp_bit_cell.
  - Combinational obit from b, seen_one and neg plus a seen_one flop.
  - Inputs: clk, rst_n, clear, enable.
  - The controller instantiates it once.

Test Plan:
- WIDTH=4, in_neg=1, in_data=4'b0101 -> out_valid rises 4 cycles after acceptance; out_data=4'b1011, out_ovf=0; in_ready low throughout.
- in_neg=1, in_data=4'b0000 -> out_data=4'b0000, out_ovf=0. Then in_data=4'b1000 -> out_data=4'b1000, out_ovf=1.
- in_neg=0, in_data=4'b0110 -> out_data=4'b0110, out_ovf=0, same 4-cycle latency.
- Backpressure: result 4'b1011 reached with out_ready=0 for 5 cycles -> out_valid, out_data and out_ovf stable; in_ready=0; a new in_valid is not accepted. Release out_ready -> one transfer, then IDLE.
- Reset mid-operation: pulse rst_n low asynchronously during SHIFT, 2 bits in -> immediate out_valid=0, in_ready=1. The next word 4'b0011 yields 4'b1101 with no trace of the aborted word.
- Exhaustive stream: all 16 values with random in_neg, random in_valid gaps and random out_ready -> every out_data matches the package reference model, out_ovf is high only for 4'b1000 with in_neg=1, and output order matches input order.
